// File: rtl/sha1_pkg.sv
// Shared constants, register map and FSM encoding for the SHA-1 accelerator.
package sha1_pkg;

  localparam logic [31:0] H_INIT0 = 32'h67452301;
  localparam logic [31:0] H_INIT1 = 32'hEFCDAB89;
  localparam logic [31:0] H_INIT2 = 32'h98BADCFE;
  localparam logic [31:0] H_INIT3 = 32'h10325476;
  localparam logic [31:0] H_INIT4 = 32'hC3D2E1F0;

  localparam logic [31:0] K_0 = 32'h5A827999;
  localparam logic [31:0] K_1 = 32'h6ED9EBA1;
  localparam logic [31:0] K_2 = 32'h8F1BBCDC;
  localparam logic [31:0] K_3 = 32'hCA62C1D6;

  localparam logic [4:0] ADDR_CTRL        = 5'd0;
  localparam logic [4:0] ADDR_MSG_BASE    = 5'd1;
  localparam logic [4:0] ADDR_DIGEST_BASE = 5'd17;
  localparam logic [4:0] ADDR_LAST        = 5'd21;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} sha1_state_e;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20) return (b & c) | (~b & d);
    else if (t >= 7'd40 && t < 7'd60) return (b & c) | (b & d) | (c & d);
    else return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] sha1_k(input logic [6:0] t);
    if (t < 7'd20) return K_0;
    else if (t < 7'd40) return K_1;
    else if (t < 7'd60) return K_2;
    else return K_3;
  endfunction

endpackage

// File: rtl/sha1_core.sv
// One-block SHA-1 engine, one round per clock. start_i is a single-cycle pulse
// that is only honoured outside LOAD/ROUND; done_o stays high until the next start.
import sha1_pkg::*;

module sha1_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [511:0] msg_i,
  output logic         done_o,
  output logic [159:0] digest_o,
  output sha1_state_e  state_o
);

  sha1_state_e  state_q, state_d;
  logic [6:0]   t_q, t_d;
  logic [31:0]  a_q, b_q, c_q, d_q, e_q;
  logic [31:0]  a_d, b_d, c_d, d_d, e_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [159:0] digest_q, digest_d;
  logic         done_q, done_d;
  logic [31:0]  temp, w_new;

  // w_q[i] holds W[t+i]; w_q[0] is the word consumed by the current round.
  assign temp  = rotl(a_q, 5) + sha1_f(t_q, b_q, c_q, d_q) + e_q + sha1_k(t_q) + w_q[0];
  assign w_new = rotl(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1);

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    e_d      = e_q;
    w_d      = w_q;
    digest_d = digest_q;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        a_d = H_INIT0;
        b_d = H_INIT1;
        c_d = H_INIT2;
        d_d = H_INIT3;
        e_d = H_INIT4;
        for (int i = 0; i < 16; i++) w_d[i] = msg_i[511-32*i -: 32];
        t_d     = 7'd0;
        state_d = ROUND;
      end
      ROUND: begin
        e_d = d_q;
        d_d = c_q;
        c_d = rotl(b_q, 30);
        b_d = a_q;
        a_d = temp;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new;
        t_d     = t_q + 7'd1;
        if (t_q == 7'd79) state_d = FINAL;
      end
      FINAL: begin
        digest_d = {H_INIT0 + a_q, H_INIT1 + b_q, H_INIT2 + c_q, H_INIT3 + d_q, H_INIT4 + e_q};
        if (start_i) begin
          state_d = LOAD;
          done_d  = 1'b0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      e_q      <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      e_q      <= e_d;
      w_q      <= w_d;
      digest_q <= digest_d;
      done_q   <= done_d;
    end
  end

  // FINAL already counts as done so a status read on the digest-write edge sees it.
  assign done_o   = done_q | (state_q == FINAL);
  assign digest_o = digest_q;
  assign state_o  = state_q;

endmodule

// File: rtl/top_level_wrapper.sv
// 32-bit slave port around sha1_core: message register file, control/status and
// digest readback with a registered, one-cycle read latency.
import sha1_pkg::*;

module top_level_wrapper (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);

  logic [31:0]  msg_q [16];
  logic [31:0]  readdata_q, readdata_d;
  logic [511:0] msg_flat;
  logic [159:0] digest;
  logic         done, busy, start, addr_ok, is_msg;
  logic [4:0]   idx;
  logic [3:0]   msg_idx;
  logic [2:0]   dig_idx;
  sha1_state_e  core_state;

  assign addr_ok = (address[31:5] == '0);
  assign idx     = address[4:0];
  assign is_msg  = addr_ok && idx >= ADDR_MSG_BASE && idx < ADDR_DIGEST_BASE;
  assign msg_idx = 4'(idx - ADDR_MSG_BASE);
  assign dig_idx = 3'(idx - ADDR_DIGEST_BASE);
  assign busy    = (core_state == LOAD) || (core_state == ROUND);
  assign start   = write && addr_ok && idx == ADDR_CTRL && writedata[0] && !busy;

  always_comb begin
    msg_flat = '0;
    for (int i = 0; i < 16; i++) msg_flat[511-32*i -: 32] = msg_q[i];
  end

  always_comb begin
    readdata_d = '0;
    if (addr_ok) begin
      if (idx == ADDR_CTRL) begin
        readdata_d = {30'b0, done, busy};
      end else if (is_msg) begin
        readdata_d = msg_q[msg_idx];
      end else if (idx >= ADDR_DIGEST_BASE && idx <= ADDR_LAST) begin
        case (dig_idx)
          3'd0:    readdata_d = digest[159:128];
          3'd1:    readdata_d = digest[127:96];
          3'd2:    readdata_d = digest[95:64];
          3'd3:    readdata_d = digest[63:32];
          default: readdata_d = digest[31:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) msg_q[i] <= '0;
      readdata_q <= '0;
    end else begin
      if (write && is_msg && !busy) msg_q[msg_idx] <= writedata;
      if (read) readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

  sha1_core u_core (
    .clk      (clk),
    .rst      (reset),
    .start_i  (start),
    .msg_i    (msg_flat),
    .done_o   (done),
    .digest_o (digest),
    .state_o  (core_state)
  );

endmodule

// File: tb/tb_top_level_wrapper.sv
// Directed and random checks of the SHA-1 accelerator against known digests and
// a behavioural SHA-1 model.
module tb_top_level_wrapper;

  logic        clk = 1'b0;
  logic        reset, write, read;
  logic [31:0] address, writedata, readdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [31:0] cur_msg [16];
  logic [31:0] exp_q [$];
  logic [31:0] rd;

  localparam logic [159:0] ABC_DIGEST   = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
  localparam logic [159:0] EMPTY_DIGEST = 160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709;

  top_level_wrapper dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .read      (read),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // reference model: straight FIPS 180 single-block compression
  function automatic logic [159:0] sha1_ref(input logic [31:0] m [16]);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 80; t++) w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rl(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rl(b, 30); b = a; a = tmp;
    end
    return {32'h67452301 + a, 32'hEFCDAB89 + b, 32'h98BADCFE + c, 32'h10325476 + d, 32'hC3D2E1F0 + e};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    read = 1'b1; address = a;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic load_msg();
    for (int i = 0; i < 16; i++) bus_write(32'(i + 1), cur_msg[i]);
  endtask

  task automatic start_hash();
    bus_write(32'd0, 32'd1);
    start_cyc = cyc;
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) cur_msg[i] = '0;
    cur_msg[0]  = 32'h61626380;
    cur_msg[15] = 32'h00000018;
  endtask

  task automatic poll_done(input string tag);
    logic [31:0] s;
    bit seen;
    int lat;
    seen = 1'b0;
    lat = 9999;
    s = '0;
    for (int n = 0; n < 200 && !seen; n++) begin
      bus_read(32'd0, s);
      if (s[1]) begin
        seen = 1'b1;
        lat = cyc - start_cyc;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency_le_82"}, 32'(lat <= 82), 32'd1);
    check({tag, " status_done"}, s, 32'd2);
  endtask

  // scoreboard: expected digest words queued, then drained against readback
  task automatic check_digest(input string tag, input logic [159:0] exp);
    logic [31:0] d;
    for (int i = 0; i < 5; i++) exp_q.push_back(exp[159-32*i -: 32]);
    for (int i = 0; i < 5; i++) begin
      bus_read(32'(17 + i), d);
      check($sformatf("%s H%0d", tag, i), d, exp_q.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset readdata", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(32'd0, rd);  check("reset status", rd, 32'd0);
    bus_read(32'd1, rd);  check("reset W0", rd, 32'd0);
    bus_read(32'd17, rd); check("reset H0", rd, 32'd0);

    // "abc"
    set_abc();
    load_msg();
    start_hash();
    poll_done("abc");
    check_digest("abc", ABC_DIGEST);
    bus_read(32'd1, rd); check("abc W0 readback", rd, 32'h61626380);

    // repeat without rewriting the message
    start_hash();
    bus_read(32'd0, rd); check("rerun status busy", rd, 32'd1);
    poll_done("rerun");
    check_digest("rerun", ABC_DIGEST);

    // empty message
    for (int i = 0; i < 16; i++) cur_msg[i] = '0;
    cur_msg[0] = 32'h80000000;
    load_msg();
    start_hash();
    poll_done("empty");
    check_digest("empty", EMPTY_DIGEST);

    // writes while busy are dropped
    set_abc();
    load_msg();
    start_hash();
    repeat (5) @(posedge clk);
    bus_write(32'd1, 32'hFFFFFFFF);
    bus_write(32'd0, 32'd1);
    bus_read(32'd0, rd); check("busy status", rd, 32'd1);
    poll_done("busy");
    check_digest("busy", ABC_DIGEST);
    bus_read(32'd1, rd); check("busy W0 kept", rd, 32'h61626380);

    // reset in the middle of a hash
    start_hash();
    while (cyc < start_cyc + 40) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midreset readdata", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(32'd0, rd); check("midreset status", rd, 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus_read(32'(17 + i), rd);
      check($sformatf("midreset H%0d", i), rd, 32'd0);
    end
    bus_read(32'd1, rd); check("midreset W0", rd, 32'd0);
    load_msg();
    start_hash();
    poll_done("postreset");
    check_digest("postreset", ABC_DIGEST);

    // unmapped addresses
    bus_read(32'd22, rd);    check("rd addr22", rd, 32'd0);
    bus_read(32'd31, rd);    check("rd addr31", rd, 32'd0);
    bus_read(32'h100, rd);   check("rd addr100", rd, 32'd0);
    bus_write(32'd22, 32'h12345678);
    bus_write(32'd31, 32'h87654321);
    bus_write(32'h101, 32'hDEADBEEF);
    bus_write(32'h100, 32'd1);
    bus_read(32'd1, rd);     check("alias W0 kept", rd, 32'h61626380);
    bus_read(32'd0, rd);     check("alias no start", rd, 32'd2);
    check_digest("alias", ABC_DIGEST);

    // random blocks against the reference model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) cur_msg[i] = $urandom;
      load_msg();
      start_hash();
      poll_done($sformatf("rand%0d", r));
      check_digest($sformatf("rand%0d", r), sha1_ref(cur_msg));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
